// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder: adds two WIDTH-bit operands plus a carry-in,
// SLICE bits per clock, over N = WIDTH/SLICE RUN cycles.
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an addition (accepted only while busy is low)
//   A, B   : operands, latched when start is accepted
//   Cin    : carry input, latched when start is accepted
//   busy   : high exactly while in RUN
//   done   : one-cycle pulse, high exactly in DONE (results valid)
//   Sum    : (A + B + Cin) mod 2^WIDTH, held until the next completion
//   Cout   : carry out of bit WIDTH-1
//   Ovf    : signed overflow (carry into MSB XOR carry out of MSB)
//
// Timing: start accepted at edge T -> busy for cycles T+1..T+N, done in T+N+1.
// A start seen in DONE re-enters RUN directly, giving a period of N+1 cycles.
module multicycle_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned N    = WIDTH / SLICE;
    // Keep the index at least one bit wide so N == 1 still elaborates.
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Slice datapath
    int unsigned      base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE:0]   slice_full;
    logic             c_into_msb;
    logic             accept;
    logic             last;

    always_comb begin
        base       = 32'(idx_q) * SLICE;
        a_sl       = a_q[base +: SLICE];
        b_sl       = b_q[base +: SLICE];
        slice_full = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from its sum bit; only meaningful
        // for the last slice, where it is the carry into bit WIDTH-1.
        c_into_msb = slice_full[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];
        last       = (idx_q == LastIdx);
        accept     = start && (state_q != StRun);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                part_d[base +: SLICE] = slice_full[SLICE-1:0];
                carry_d               = slice_full[SLICE];
                if (last) begin
                    // Results become visible only when entering DONE.
                    idx_d   = '0;
                    sum_d   = part_d;
                    cout_d  = slice_full[SLICE];
                    ovf_d   = slice_full[SLICE] ^ c_into_msb;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench for multicycle_adder (WIDTH=16, SLICE=4) plus a
// single-slice instance (WIDTH=8, SLICE=8). Inputs are driven and outputs
// sampled on the falling edge.
module tb_multicycle_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    logic        s1_start;
    logic [7:0]  s1_a;
    logic [7:0]  s1_b;
    logic        s1_cin;
    logic        s1_busy;
    logic        s1_done;
    logic [7:0]  s1_sum;
    logic        s1_cout;
    logic        s1_ovf;

    int passed;
    int total;

    multicycle_adder #(
        .WIDTH(16),
        .SLICE(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .busy (busy),
        .done (done),
        .Sum  (Sum),
        .Cout (Cout),
        .Ovf  (Ovf)
    );

    multicycle_adder #(
        .WIDTH(8),
        .SLICE(8)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(s1_start),
        .A    (s1_a),
        .B    (s1_b),
        .Cin  (s1_cin),
        .busy (s1_busy),
        .done (s1_done),
        .Sum  (s1_sum),
        .Cout (s1_cout),
        .Ovf  (s1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // One full operation from an idle negedge; returns at the negedge after done.
    task automatic run_op(input string tag, input vec_t v);
        logic [15:0] prev;
        int          busy_n;
        bit          seen;
        bit          held;
        prev   = Sum;
        held   = 1'b1;
        busy_n = 0;
        seen   = 1'b0;
        start  = 1'b1;
        A      = v.a;
        B      = v.b;
        Cin    = v.cin;
        @(negedge clk);
        start = 1'b0;
        A     = 16'hdead;
        B     = 16'hbeef;
        Cin   = 1'b1;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (Sum !== prev) held = 1'b0;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
        check({tag, " sum_held"}, 32'(held), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(Sum), 32'(v.sum));
        check({tag, " cout"}, 32'(Cout), 32'(v.cout));
        check({tag, " ovf"}, 32'(Ovf), 32'(v.ovf));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[8];
    vec_t b2b[3];

    initial begin
        int          cyc_last;
        int          k;
        bit          any_act;
        passed = 0;
        total  = 0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        b2b[0] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
        b2b[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        b2b[2] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        Cin      = 1'b0;
        s1_start = 1'b0;
        s1_a     = '0;
        s1_b     = '0;
        s1_cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(Sum), 32'd0);
        check("rst cout", 32'(Cout), 32'd0);
        check("rst ovf", 32'(Ovf), 32'd0);

        // First start right after release must be accepted at the next edge.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // start held high; operands churn during busy and must be ignored.
        start    = 1'b1;
        A        = b2b[0].a;
        B        = b2b[0].b;
        Cin      = b2b[0].cin;
        k        = 0;
        cyc_last = -1;
        for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                check($sformatf("b2b%0d sum", k), 32'(Sum), 32'(b2b[k].sum));
                check($sformatf("b2b%0d cout", k), 32'(Cout), 32'(b2b[k].cout));
                check($sformatf("b2b%0d ovf", k), 32'(Ovf), 32'(b2b[k].ovf));
                if (k > 0) check($sformatf("b2b%0d period", k), 32'(cyc - cyc_last), 32'd5);
                cyc_last = cyc;
                k++;
                if (k < 3) begin
                    A   = b2b[k].a;
                    B   = b2b[k].b;
                    Cin = b2b[k].cin;
                end else begin
                    start = 1'b0;
                end
            end else begin
                A   = A ^ 16'h5A5A;
                B   = B + 16'h0101;
                Cin = ~Cin;
            end
        end
        start = 1'b0;
        check("b2b count", 32'(k), 32'd3);
        @(negedge clk);

        // Reset in the second RUN cycle aborts; start during reset is dropped.
        start = 1'b1;
        A     = 16'hFFFF;
        B     = 16'h0001;
        Cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        A     = 16'h0001;
        B     = 16'h0001;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(Sum), 32'd0);
        check("abort cout", 32'(Cout), 32'd0);
        check("abort ovf", 32'(Ovf), 32'd0);
        rst_n   = 1'b1;
        start   = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) any_act = 1'b1;
        end
        check("abort quiet", 32'(any_act), 32'd0);
        run_op("post_abort", vecs[7]);

        // Single-slice instance: one RUN cycle, done on the next.
        s1_start = 1'b1;
        s1_a     = 8'h7F;
        s1_b     = 8'h01;
        s1_cin   = 1'b0;
        @(negedge clk);
        s1_start = 1'b0;
        check("n1 busy", 32'(s1_busy), 32'd1);
        check("n1 early_done", 32'(s1_done), 32'd0);
        check("n1 sum_hidden", 32'(s1_sum), 32'd0);
        @(negedge clk);
        check("n1 done", 32'(s1_done), 32'd1);
        check("n1 busy_off", 32'(s1_busy), 32'd0);
        check("n1 sum", 32'(s1_sum), 32'h80);
        check("n1 cout", 32'(s1_cout), 32'd0);
        check("n1 ovf", 32'(s1_ovf), 32'd1);
        @(negedge clk);
        check("n1 done_pulse", 32'(s1_done), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
